// File: rtl/shift_scheduler_pkg.sv
// Shared definitions for the coordinate-shifter scheduler: FSM state
// encodings, default widths and small width helpers.
package shift_scheduler_pkg;

   localparam int unsigned DEF_COORD_W = 8;
   localparam int unsigned DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Index width for n requesters; never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Timeout counter width; at least four bits.
   function automatic int unsigned cnt_width(input int unsigned t);
      int unsigned w;
      w = $clog2(t + 1);
      return (w < 4) ? 4 : w;
   endfunction

endpackage

// File: rtl/shift_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter
   import shift_scheduler_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant_c,
   output logic [IW-1:0] idx_c,
   output logic          any_c
);

   int unsigned  sum;
   logic [IW-1:0] pos;

   // Scan N positions starting at ptr; first hit wins.
   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      sum     = 0;
      pos     = '0;
      if (en) begin
         for (int unsigned k = 0; k < N; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= N) begin
               sum = sum - N;
            end
            pos = IW'(sum);
            if (!any_c && req[pos]) begin
               any_c        = 1'b1;
               grant_c[pos] = 1'b1;
               idx_c        = pos;
            end
         end
      end
   end

endmodule

// File: rtl/shift_scheduler.sv
// Shares one coordinate shifter between NUM_REQ requesters: round-robin
// grant, operand latch, wait for the shifter result, one-cycle DONE.
// Optional feature macro: SHIFT_TIMEOUT_EN (bounded wait for SH_VALID,
// ERR flagged with zero results on expiry).
module shift_scheduler
   import shift_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned COORD_W = DEF_COORD_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [NUM_REQ-1:0]           REQ,
   input  logic [NUM_REQ*COORD_W-1:0]   REQ_XCOORD,
   input  logic [NUM_REQ*COORD_W-1:0]   REQ_YCOORD,
   input  logic [NUM_REQ*COORD_W-1:0]   REQ_XCENTER,
   input  logic [NUM_REQ*COORD_W-1:0]   REQ_YCENTER,
   output logic [NUM_REQ-1:0]           GNT,
   output logic [NUM_REQ-1:0]           DONE,
   output logic [COORD_W-1:0]           RES_X,
   output logic [COORD_W-1:0]           RES_Y,
   output logic                         ERR,
   output logic                         BUSY,
   output logic                         SH_ENB,
   output logic [COORD_W-1:0]           SH_XCOORD,
   output logic [COORD_W-1:0]           SH_YCOORD,
   output logic [COORD_W-1:0]           SH_XCENTER,
   output logic [COORD_W-1:0]           SH_YCENTER,
   input  logic [COORD_W-1:0]           SH_XOUT,
   input  logic [COORD_W-1:0]           SH_YOUT,
   input  logic                         SH_VALID
);

   localparam int unsigned IW = idx_width(NUM_REQ);

   // Elaboration-time parameter sanity.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
      $error("shift_scheduler: NUM_REQ must be 2..8");
   end
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("shift_scheduler: TIMEOUT must be at least 1");
   end

   state_e               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [COORD_W-1:0]   res_x_q, res_x_d;
   logic [COORD_W-1:0]   res_y_q, res_y_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 sh_enb_q, sh_enb_d;
   logic [COORD_W-1:0]   sh_x_q, sh_x_d;
   logic [COORD_W-1:0]   sh_y_q, sh_y_d;
   logic [COORD_W-1:0]   sh_xc_q, sh_xc_d;
   logic [COORD_W-1:0]   sh_yc_q, sh_yc_d;
   logic                 timeout_hit_c;

   logic [NUM_REQ-1:0]   arb_grant_c;
   logic [IW-1:0]        arb_idx_c;
   logic                 arb_any_c;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req     (REQ),
      .ptr     (ptr_q),
      .en      (state_q == ST_IDLE),
      .grant_c (arb_grant_c),
      .idx_c   (arb_idx_c),
      .any_c   (arb_any_c)
   );

`ifdef SHIFT_TIMEOUT_EN
   localparam int unsigned CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Cycles spent in ISSUE/WAIT; cleared on grant.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE) begin
         cnt_d = '0;
      end else if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Timeout counter register.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_hit_c = (cnt_q == CW'(TIMEOUT));
`else
   assign timeout_hit_c = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      gnt_d    = '0;
      done_d   = '0;
      res_x_d  = res_x_q;
      res_y_d  = res_y_q;
      err_d    = err_q;
      sh_enb_d = 1'b0;
      sh_x_d   = sh_x_q;
      sh_y_d   = sh_y_q;
      sh_xc_d  = sh_xc_q;
      sh_yc_d  = sh_yc_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any_c) begin
               sh_x_d   = REQ_XCOORD [32'(arb_idx_c) * COORD_W +: COORD_W];
               sh_y_d   = REQ_YCOORD [32'(arb_idx_c) * COORD_W +: COORD_W];
               sh_xc_d  = REQ_XCENTER[32'(arb_idx_c) * COORD_W +: COORD_W];
               sh_yc_d  = REQ_YCENTER[32'(arb_idx_c) * COORD_W +: COORD_W];
               idx_d    = arb_idx_c;
               gnt_d    = arb_grant_c;
               ptr_d    = (arb_idx_c == IW'(NUM_REQ - 1)) ? '0 : arb_idx_c + IW'(1);
               sh_enb_d = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (SH_VALID) begin
               res_x_d = SH_XOUT;
               res_y_d = SH_YOUT;
               err_d   = 1'b0;
               done_d  = NUM_REQ'(1) << idx_q;
               state_d = ST_RESP;
            end else if (timeout_hit_c) begin
               res_x_d = '0;
               res_y_d = '0;
               err_d   = 1'b1;
               done_d  = NUM_REQ'(1) << idx_q;
               state_d = ST_RESP;
            end else begin
               sh_enb_d = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         res_x_q  <= '0;
         res_y_q  <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         sh_enb_q <= 1'b0;
         sh_x_q   <= '0;
         sh_y_q   <= '0;
         sh_xc_q  <= '0;
         sh_yc_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         res_x_q  <= res_x_d;
         res_y_q  <= res_y_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         sh_enb_q <= sh_enb_d;
         sh_x_q   <= sh_x_d;
         sh_y_q   <= sh_y_d;
         sh_xc_q  <= sh_xc_d;
         sh_yc_q  <= sh_yc_d;
      end
   end

   assign GNT        = gnt_q;
   assign DONE       = done_q;
   assign RES_X      = res_x_q;
   assign RES_Y      = res_y_q;
   assign ERR        = err_q;
   assign BUSY       = busy_q;
   assign SH_ENB     = sh_enb_q;
   assign SH_XCOORD  = sh_x_q;
   assign SH_YCOORD  = sh_y_q;
   assign SH_XCENTER = sh_xc_q;
   assign SH_YCENTER = sh_yc_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler: single op, fairness, wrap, stale
// VALID, reset mid-WAIT and long-latency / timeout behaviour.
module tb_shift_scheduler;

   localparam int NR = 4;
   localparam int CW = 8;

   logic              clk = 1'b0;
   logic              areset;
   logic [NR-1:0]     req;
   logic [NR*CW-1:0]  req_x, req_y, req_xc, req_yc;
   logic [NR-1:0]     gnt, done;
   logic [CW-1:0]     res_x, res_y;
   logic              err, busy, sh_enb;
   logic [CW-1:0]     sh_x, sh_y, sh_xc, sh_yc;
   logic [CW-1:0]     sh_xout, sh_yout;
   logic              sh_valid;

   logic [CW-1:0]     tx[NR], ty[NR], txc[NR], tyc[NR];
   logic [NR*CW-1:0]  px, py, pxc, pyc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_scheduler #(
      .NUM_REQ (NR),
      .COORD_W (CW),
      .TIMEOUT (15)
   ) dut (
      .ACLK        (clk),
      .ARESET      (areset),
      .REQ         (req),
      .REQ_XCOORD  (req_x),
      .REQ_YCOORD  (req_y),
      .REQ_XCENTER (req_xc),
      .REQ_YCENTER (req_yc),
      .GNT         (gnt),
      .DONE        (done),
      .RES_X       (res_x),
      .RES_Y       (res_y),
      .ERR         (err),
      .BUSY        (busy),
      .SH_ENB      (sh_enb),
      .SH_XCOORD   (sh_x),
      .SH_YCOORD   (sh_y),
      .SH_XCENTER  (sh_xc),
      .SH_YCENTER  (sh_yc),
      .SH_XOUT     (sh_xout),
      .SH_YOUT     (sh_yout),
      .SH_VALID    (sh_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic restore_ops();
      req_x  = px;
      req_y  = py;
      req_xc = pxc;
      req_yc = pyc;
   endtask

   task automatic wait_gnt(output int cycles);
      cycles = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (gnt != '0) begin
            cycles = k;
            break;
         end
      end
   endtask

   // One full operation; shifter model answers lat cycles after ENB rises.
   task automatic op(input logic [NR-1:0] eg, input int lat, input logic [NR-1:0] nreq,
                     input int gnt_lat);
      int cyc;
      int idx;
      logic [CW-1:0] ex, ey;
      wait_gnt(cyc);
      chk("gnt", gnt, eg);
      if (gnt_lat > 0) chk("gnt_latency", cyc, gnt_lat);
      idx = 0;
      for (int i = 0; i < NR; i++) if (eg[i]) idx = i;
      ex = tx[idx] + txc[idx];
      ey = ty[idx] + tyc[idx];
      chk("sh_xcoord", sh_x, tx[idx]);
      chk("sh_ycoord", sh_y, ty[idx]);
      chk("sh_xcenter", sh_xc, txc[idx]);
      chk("sh_ycenter", sh_yc, tyc[idx]);
      chk("sh_enb_issue", sh_enb, 1);
      chk("busy_issue", busy, 1);
      req    = nreq;
      req_x  = ~px;
      req_y  = ~py;
      req_xc = ~pxc;
      req_yc = ~pyc;
      repeat (lat) step();
      if (lat > 0) begin
         chk("done_early", done, 0);
         chk("sh_enb_wait", sh_enb, 1);
      end
      sh_valid = 1'b1;
      sh_xout  = ex;
      sh_yout  = ey;
      step();
      sh_valid = 1'b0;
      chk("done", done, eg);
      chk("res_x", res_x, ex);
      chk("res_y", res_y, ey);
      chk("err", err, 0);
      chk("sh_enb_resp", sh_enb, 0);
      chk("sh_x_stable", sh_x, tx[idx]);
      restore_ops();
   endtask

`ifdef SHIFT_TIMEOUT_EN
   // Operation whose shifter never answers.
   task automatic op_timeout(input logic [NR-1:0] eg);
      int cyc;
      wait_gnt(cyc);
      chk("to_gnt", gnt, eg);
      req = '0;
      repeat (15) step();
      chk("to_done_early", done, 0);
      chk("to_busy", busy, 1);
      step();
      chk("to_done", done, eg);
      chk("to_err", err, 1);
      chk("to_res_x", res_x, 0);
      chk("to_res_y", res_y, 0);
      step();
      chk("to_idle_busy", busy, 0);
   endtask
`endif

   initial begin
      int cyc;
      logic [NR-1:0] eg;
      logic [CW-1:0] last_x;

      tx[0] = 8'h01; ty[0] = 8'h02; txc[0] = 8'h08; tyc[0] = 8'h03;
      tx[1] = 8'h10; ty[1] = 8'h05; txc[1] = 8'h20; tyc[1] = 8'h00;
      tx[2] = 8'h3C; ty[2] = 8'h44; txc[2] = 8'h11; tyc[2] = 8'h21;
      tx[3] = 8'h7E; ty[3] = 8'h19; txc[3] = 8'h02; tyc[3] = 8'h40;
      for (int i = 0; i < NR; i++) begin
         px [i*CW +: CW] = tx[i];
         py [i*CW +: CW] = ty[i];
         pxc[i*CW +: CW] = txc[i];
         pyc[i*CW +: CW] = tyc[i];
      end
      restore_ops();
      areset   = 1'b1;
      req      = '0;
      sh_valid = 1'b0;
      sh_xout  = '0;
      sh_yout  = '0;
      step();
      step();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_res_x", res_x, 0);
      chk("rst_res_y", res_y, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sh_enb", sh_enb, 0);
      chk("rst_sh_x", sh_x, 0);
      areset = 1'b0;
      step();

      // Single request from requester 1: result 0x30/0x05.
      req = 4'b0010;
      op(4'b0010, 2, 4'b0000, 1);
      chk("single_res_x", res_x, 8'h30);
      step();
      chk("single_idle_done", done, 0);
      chk("single_idle_busy", busy, 0);
      chk("single_res_hold", res_x, 8'h30);

      // Fairness from a fresh pointer; latencies 0..2 cover the ISSUE shortcut.
      areset = 1'b1;
      step();
      areset = 1'b0;
      req = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         eg = 4'b0001 << (n % 4);
         op(eg, n % 3, (n == 7) ? 4'b0000 : 4'b1111, (n == 0) ? 1 : 2);
      end

      // Wrap: pointer moved to 3, then 0101 grants 0 before 2.
      step();
      req = 4'b0100;
      op(4'b0100, 1, 4'b0000, 0);
      req = 4'b0101;
      op(4'b0001, 1, 4'b0101, 0);
      op(4'b0100, 1, 4'b0000, 0);

      // Stale VALID in IDLE is ignored.
      step();
      last_x   = res_x;
      sh_valid = 1'b1;
      sh_xout  = 8'hAA;
      sh_yout  = 8'hBB;
      step();
      sh_valid = 1'b0;
      chk("stale_done", done, 0);
      chk("stale_busy", busy, 0);
      chk("stale_res_x", res_x, last_x);
      req = 4'b1000;
      op(4'b1000, 3, 4'b0000, 1);

      // Reset in WAIT abandons the op; pointer returns to requester 0.
      step();
      req = 4'b0100;
      wait_gnt(cyc);
      chk("rw_gnt", gnt, 4'b0100);
      req = '0;
      step();
      step();
      chk("rw_sh_enb", sh_enb, 1);
      chk("rw_busy", busy, 1);
      areset = 1'b1;
      step();
      areset = 1'b0;
      chk("rw_busy_rst", busy, 0);
      chk("rw_sh_enb_rst", sh_enb, 0);
      chk("rw_done_rst", done, 0);
      sh_valid = 1'b1;
      sh_xout  = 8'h55;
      step();
      sh_valid = 1'b0;
      chk("rw_late_done", done, 0);
      step();
      chk("rw_late_done2", done, 0);
      chk("rw_late_busy", busy, 0);
      req = 4'b1111;
      op(4'b0001, 1, 4'b0000, 1);

      step();
`ifdef SHIFT_TIMEOUT_EN
      req = 4'b0010;
      op_timeout(4'b0010);
`else
      // Long latency with no timeout: the op still completes cleanly.
      req = 4'b0010;
      op(4'b0010, 20, 4'b0000, 1);
`endif

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/shift_scheduler.md
Name: shift_scheduler

Overview:
- Shares one coordinate shifter datapath between NUM_REQ requesters (sprite, cursor and text units).
- Arbitrates round-robin, latches the winner's coordinate/center operands, and drives the shifter.
- Waits for the shifter's VALID, then returns Xout/Yout to the winner with a one-cycle DONE pulse.
- Sits between the pixel-pipeline units and the single shifter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- COORD_W, 8, width of every coordinate and center field.
- TIMEOUT, 15, max cycles waited for SH_VALID (used only with SHIFT_TIMEOUT_EN).

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  synchronous active-high reset.
- REQ  in  NUM_REQ  per-requester request, level.
- REQ_XCOORD  in  NUM_REQ*COORD_W  packed X coordinates; requester i in slice [i*COORD_W +: COORD_W].
- REQ_YCOORD  in  NUM_REQ*COORD_W  packed Y coordinates, same slicing.
- REQ_XCENTER  in  NUM_REQ*COORD_W  packed X centers, same slicing.
- REQ_YCENTER  in  NUM_REQ*COORD_W  packed Y centers, same slicing.
- GNT  out  NUM_REQ  one-hot, one-cycle pulse: operands of that requester latched.
- DONE  out  NUM_REQ  one-hot, one-cycle pulse: result ready for that requester.
- RES_X  out  COORD_W  shifted X, valid with DONE.
- RES_Y  out  COORD_W  shifted Y, valid with DONE.
- ERR  out  1  high with DONE if the operation timed out.
- BUSY  out  1  high whenever state is not IDLE.
- SH_ENB  out  1  shifter enable.
- SH_XCOORD  out  COORD_W  shifter X coordinate operand.
- SH_YCOORD  out  COORD_W  shifter Y coordinate operand.
- SH_XCENTER  out  COORD_W  shifter X center operand.
- SH_YCENTER  out  COORD_W  shifter Y center operand.
- SH_XOUT  in  COORD_W  shifter X result.
- SH_YOUT  in  COORD_W  shifter Y result.
- SH_VALID  in  1  shifter result valid.

Behaviour:
- Reset (ARESET high at a rising edge):
  - All outputs 0; state IDLE.
  - Round-robin pointer = requester 0, which gets highest priority first.
  - Reset mid-operation abandons the operation: no DONE is issued, any later SH_VALID is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any REQ bit is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch its four operand slices into SH_* registers and store its index.
  - Pulse GNT[idx] for one cycle; move pointer to idx+1 (wrapping); go to ISSUE.
  - GNT is registered: REQ seen at edge n gives GNT high during cycle n+1.
- ISSUE:
  - SH_ENB=1; go to WAIT.
  - If SH_VALID is high in this cycle, capture the result and go directly to RESP.
- WAIT:
  - SH_ENB=1; SH_* operands held stable.
  - On SH_VALID, capture SH_XOUT/SH_YOUT into RES_X/RES_Y and go to RESP.
- RESP:
  - DONE[idx]=1 for exactly one cycle; SH_ENB=0; go to IDLE.
  - A new grant is possible on the next edge, so throughput is one op per (shifter latency + 3) cycles.
- SH_VALID in IDLE or RESP is ignored; stale results are dropped.
- RES_X/RES_Y/ERR hold their values until the next RESP.
- A requester still asserting REQ after GNT is treated as a new request. It competes at the lowest priority behind the others.
- Operand changes on REQ_* after GNT have no effect on the current operation.
- All coordinate data passes through unmodified; no arithmetic is done in this block.

Optional Feature:
- SHIFT_TIMEOUT_EN defined:
  - A 4-bit-minimum counter ($clog2(TIMEOUT+1)) clears on entry to ISSUE and counts in ISSUE/WAIT.
  - If it reaches TIMEOUT without SH_VALID, go to RESP with ERR=1 and RES_X/RES_Y = 0.
  - SH_VALID and timeout in the same cycle: SH_VALID wins, ERR=0.
- SHIFT_TIMEOUT_EN undefined:
  - No counter; WAIT persists until SH_VALID.
  - ERR tied to 0.

Decomposition:
- Shared header superga_defs.vh holds:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - default COORD_W=8;
  - default TIMEOUT.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs req, ptr, en; outputs one-hot grant, encoded index, any.
  - Purely combinational pick logic; the pointer register stays in shift_scheduler.

Test Plan:
- Single request: REQ=4'b0010, slice 1 X=0x10, Y=0x05, XC=0x20, YC=0x00; shifter model returns VALID 2 cycles after ENB with XOUT=0x30, YOUT=0x05 -> GNT=0010 one cycle after REQ, SH_* = 0x10/0x05/0x20/0x00, DONE=0010 with RES_X=0x30, RES_Y=0x05, ERR=0.
- Fairness: REQ=4'b1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3, with exactly one DONE per GNT.
- Wrap: pointer at 3, REQ=4'b0101 -> grant requester 0, then 2.
- Stale VALID: pulse SH_VALID while IDLE, then issue a request -> no DONE until the model's real VALID; result taken from the real VALID only.
- Reset mid-WAIT: assert ARESET for 1 cycle in WAIT, then SH_VALID arrives -> no DONE, BUSY=0, next grant goes to requester 0.
- Timeout (SHIFT_TIMEOUT_EN, TIMEOUT=15): model never asserts VALID -> DONE 16 cycles after ISSUE entry with ERR=1, RES_X=RES_Y=0x00.
